// File: rtl/washer_phase_timer_if.sv
// Bundle between the washer cycle FSM (master) and its phase-duration timer (slave).
// The FSM drives the phase request; the timer reports progress and completion.
interface washer_phase_timer_if #(
  parameter int unsigned CNT_W = 8
);
  logic             timer_enable;
  logic [1:0]       phase_sel;
  logic [2:0]       mode;
  logic             pause;
  logic             timer_done;
  logic             running;
  logic [CNT_W-1:0] remaining;

  modport master (
    output timer_enable, phase_sel, mode, pause,
    input  timer_done, running, remaining
  );

  modport slave (
    input  timer_enable, phase_sel, mode, pause,
    output timer_done, running, remaining
  );
endinterface

// File: rtl/washer_phase_timer.sv
// Programmable phase-duration timer: counts mode-scaled units per washer phase,
// freezes while the lid is open and reloads on every phase change or re-enable.
module washer_phase_timer #(
  parameter int unsigned TICK_DIV = 1000,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned SOAK_T   = 6,
  parameter int unsigned WASH_T   = 10,
  parameter int unsigned RINSE_T  = 4,
  parameter int unsigned SPIN_T   = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  washer_phase_timer_if.slave   bus
);

  localparam int unsigned DW = CNT_W + 1;
  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]    PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0]    D_MAX    = DW'({CNT_W{1'b1}});

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [PW-1:0]    prescaler;
  logic [CNT_W-1:0] remaining;
  logic             timer_done;
  logic             en_q;
  logic [1:0]       phase_q;

  logic [DW-1:0]    base_c;
  logic [DW-1:0]    scaled_c;
  logic [CNT_W-1:0] dur_c;
  logic             reload_c;
  logic             tick_c;

  // Base duration of the requested phase, widened by one bit for the heavy shift
  always_comb begin
    base_c = DW'(SOAK_T);
    case (bus.phase_sel)
      2'b00:   base_c = DW'(SOAK_T);
      2'b01:   base_c = DW'(WASH_T);
      2'b10:   base_c = DW'(RINSE_T);
      default: base_c = DW'(SPIN_T);
    endcase
  end

  // Mode scaling (heavy > normal > quick), then saturate high and clamp zero to one
  always_comb begin
    scaled_c = base_c;
    if (bus.mode[2]) begin
      scaled_c = base_c << 1;
    end else if (bus.mode[1]) begin
      scaled_c = base_c;
    end else if (bus.mode[0]) begin
      scaled_c = base_c >> 1;
    end

    dur_c = scaled_c[CNT_W-1:0];
    if (scaled_c > D_MAX) begin
      dur_c = D_MAX[CNT_W-1:0];
    end else if (scaled_c == '0) begin
      dur_c = CNT_W'(1);
    end
  end

  // A fresh enable or any phase change restarts the phase from full duration
  assign reload_c = bus.timer_enable && (!en_q || (bus.phase_sel != phase_q));
  assign tick_c   = (prescaler == PRE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      prescaler  <= '0;
      remaining  <= '0;
      timer_done <= 1'b0;
      en_q       <= 1'b0;
      phase_q    <= 2'b00;
    end else begin
      en_q    <= bus.timer_enable;
      phase_q <= bus.phase_sel;

      if (!bus.timer_enable) begin
        state      <= ST_IDLE;
        prescaler  <= '0;
        remaining  <= '0;
        timer_done <= 1'b0;
      end else if (reload_c) begin
        state      <= ST_COUNT;
        prescaler  <= '0;
        remaining  <= dur_c;
        timer_done <= 1'b0;
      end else begin
        case (state)
          ST_COUNT: begin
            if (!bus.pause) begin
              if (tick_c) begin
                prescaler <= '0;
                remaining <= remaining - CNT_W'(1);
                if (remaining == CNT_W'(1)) begin
                  state      <= ST_DONE;
                  timer_done <= 1'b1;
                end
              end else begin
                prescaler <= prescaler + PW'(1);
              end
            end
          end
          // Done is held through pause so a lid-blocked FSM can advance later
          ST_DONE: begin
            timer_done <= 1'b1;
            remaining  <= '0;
            prescaler  <= '0;
          end
          default: begin
            state      <= ST_IDLE;
            prescaler  <= '0;
            remaining  <= '0;
            timer_done <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.timer_done = timer_done;
  assign bus.remaining  = remaining;
  assign bus.running    = (state == ST_COUNT) && !bus.pause;

endmodule

// File: tb/tb_washer_phase_timer.sv
// Scoreboard bench for washer_phase_timer: expectations are queued as stimulus is
// applied and popped against DUT outputs sampled on the falling clock edge.
module tb_washer_phase_timer;

  localparam int unsigned TD    = 4;
  localparam int unsigned CW    = 8;
  localparam int          LIMIT = 300;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  washer_phase_timer_if #(.CNT_W(CW)) a ();
  washer_phase_timer_if #(.CNT_W(CW)) b ();

  washer_phase_timer #(.TICK_DIV(TD), .CNT_W(CW)) u_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a)
  );

  washer_phase_timer #(.TICK_DIV(TD), .CNT_W(CW), .WASH_T(200), .SPIN_T(1)) u_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    string tag;
    int    want;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string tag, input int act, input int want);
    vectors++;
    if (act != want) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, want);
    end
  endtask

  task automatic push_exp(input string tag, input int want);
    exp_t e;
    e.tag  = tag;
    e.want = want;
    exp_q.push_back(e);
  endtask

  task automatic pop_cmp(input int act);
    exp_t e;
    check("sb_nonempty", int'(exp_q.size() > 0), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(e.tag, act, e.want);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_a(input bit en, input bit [1:0] ph, input bit [2:0] md, input bit ps);
    a.timer_enable = en;
    a.phase_sel    = ph;
    a.mode         = md;
    a.pause        = ps;
  endtask

  task automatic set_b(input bit en, input bit [1:0] ph, input bit [2:0] md, input bit ps);
    b.timer_enable = en;
    b.phase_sel    = ph;
    b.mode         = md;
    b.pause        = ps;
  endtask

  // Edges from the load edge until timer_done is seen, bounded
  task automatic wait_done(input bit sel, input int load_cyc, output int lat);
    int n;
    n = 0;
    while (((sel ? b.timer_done : a.timer_done) !== 1'b1) && (n < LIMIT)) begin
      @(negedge clk);
      n++;
    end
    check("done_in_time", int'(n < LIMIT), 1);
    lat = cyc - load_cyc;
  endtask

  int c0;
  int lat;
  int n;

  initial begin
    set_a(1'b0, 2'd0, 3'd0, 1'b0);
    set_b(1'b0, 2'd0, 3'd0, 1'b0);
    rst_n = 1'b0;
    step(2);

    // Reset state
    push_exp("rst_done", 0); push_exp("rst_run", 0); push_exp("rst_rem", 0);
    pop_cmp(int'(a.timer_done)); pop_cmp(int'(a.running)); pop_cmp(int'(a.remaining));
    rst_n = 1'b1;
    step(1);

    // Normal soak: D=6, tick every 4 cycles, done 24 cycles after load
    set_a(1'b1, 2'd0, 3'b010, 1'b0);
    push_exp("soak_load", 6); push_exp("soak_run", 1);
    step(1); c0 = cyc;
    pop_cmp(int'(a.remaining)); pop_cmp(int'(a.running));
    push_exp("soak_e3", 6); step(3); pop_cmp(int'(a.remaining));
    push_exp("soak_e4", 5); step(1); pop_cmp(int'(a.remaining));
    push_exp("soak_lat", 24);
    wait_done(1'b0, c0, lat); pop_cmp(lat);
    push_exp("soak_hold", 1); push_exp("soak_hold_rem", 0); push_exp("soak_hold_run", 0);
    step(3);
    pop_cmp(int'(a.timer_done)); pop_cmp(int'(a.remaining)); pop_cmp(int'(a.running));

    // Pause while done keeps done asserted
    a.pause = 1'b1;
    push_exp("done_pause", 1); push_exp("done_pause_run", 0);
    step(2);
    pop_cmp(int'(a.timer_done)); pop_cmp(int'(a.running));
    a.pause = 1'b0;

    // Phase advance soak->wash: done drops, normal wash reloads to 10
    a.phase_sel = 2'd1;
    push_exp("adv_done", 0); push_exp("adv_rem", 10); push_exp("adv_run", 1);
    step(1);
    pop_cmp(int'(a.timer_done)); pop_cmp(int'(a.remaining)); pop_cmp(int'(a.running));
    push_exp("adv_tick", 9); step(4); pop_cmp(int'(a.remaining));

    // Mid-count phase jump discards the old count
    a.phase_sel = 2'd2;
    push_exp("jump_rem", 4); step(1); pop_cmp(int'(a.remaining));

    // Cancel at remaining=3, then re-enable reloads full D
    n = 0;
    while ((a.remaining != CW'(3)) && (n < LIMIT)) begin
      step(1);
      n++;
    end
    check("rem3_in_time", int'(n < LIMIT), 1);
    a.timer_enable = 1'b0;
    push_exp("cancel_rem", 0); push_exp("cancel_done", 0); push_exp("cancel_run", 0);
    step(1);
    pop_cmp(int'(a.remaining)); pop_cmp(int'(a.timer_done)); pop_cmp(int'(a.running));
    a.timer_enable = 1'b1;
    push_exp("reen_rem", 4); step(1); pop_cmp(int'(a.remaining));

    // Heavy wash: D=20, done at 80
    a.timer_enable = 1'b0; step(1);
    set_a(1'b1, 2'd1, 3'b100, 1'b0);
    push_exp("heavy_rem", 20); push_exp("heavy_lat", 80);
    step(1); c0 = cyc; pop_cmp(int'(a.remaining));
    wait_done(1'b0, c0, lat); pop_cmp(lat);

    // Quick rinse: D=2, done at 8
    a.timer_enable = 1'b0; step(1);
    set_a(1'b1, 2'd2, 3'b001, 1'b0);
    push_exp("quick_rem", 2); push_exp("quick_lat", 8);
    step(1); c0 = cyc; pop_cmp(int'(a.remaining));
    wait_done(1'b0, c0, lat); pop_cmp(lat);

    // Pause 10 cycles from cycle 5 of a normal soak; mid-phase mode change ignored
    a.timer_enable = 1'b0; step(1);
    set_a(1'b1, 2'd0, 3'b010, 1'b0);
    push_exp("psoak_load", 6);
    step(1); c0 = cyc; pop_cmp(int'(a.remaining));
    step(4);
    a.pause = 1'b1;
    a.mode  = 3'b100;
    push_exp("pause_rem", 5); push_exp("pause_run", 0);
    step(1); pop_cmp(int'(a.remaining)); pop_cmp(int'(a.running));
    push_exp("pause_rem_hold", 5);
    step(9); pop_cmp(int'(a.remaining));
    a.pause = 1'b0;
    push_exp("pause_lat", 34);
    wait_done(1'b0, c0, lat); pop_cmp(lat);

    // Enable drop together with a phase change goes idle without reloading
    a.timer_enable = 1'b0; step(1);
    set_a(1'b1, 2'd3, 3'b010, 1'b0);
    push_exp("spin_rem", 5); step(1); pop_cmp(int'(a.remaining));
    step(3);
    a.timer_enable = 1'b0;
    a.phase_sel    = 2'd0;
    push_exp("drop_rem", 0); push_exp("drop_done", 0); push_exp("drop_run", 0);
    step(1);
    pop_cmp(int'(a.remaining)); pop_cmp(int'(a.timer_done)); pop_cmp(int'(a.running));
    push_exp("drop_stay", 0); step(2); pop_cmp(int'(a.remaining));

    // Asynchronous reset mid-count clears outputs at once
    set_a(1'b1, 2'd1, 3'b010, 1'b0);
    push_exp("pre_rst_rem", 10); step(1); pop_cmp(int'(a.remaining));
    step(5);
    #2 rst_n = 1'b0;
    #1;
    push_exp("arst_rem", 0); push_exp("arst_done", 0); push_exp("arst_run", 0);
    pop_cmp(int'(a.remaining)); pop_cmp(int'(a.timer_done)); pop_cmp(int'(a.running));
    @(negedge clk);
    rst_n = 1'b1;
    push_exp("post_rst_rem", 10); step(1); pop_cmp(int'(a.remaining));

    // Saturation: 200<<1 exceeds 8 bits -> 255
    set_b(1'b1, 2'd1, 3'b100, 1'b0);
    push_exp("sat_rem", 255); step(1); pop_cmp(int'(b.remaining));

    // Quick spin with base 1 clamps to 1, done after one tick period
    b.timer_enable = 1'b0; step(1);
    set_b(1'b1, 2'd3, 3'b001, 1'b0);
    push_exp("clamp_rem", 1); push_exp("clamp_lat", 4);
    step(1); c0 = cyc; pop_cmp(int'(b.remaining));
    wait_done(1'b1, c0, lat); pop_cmp(lat);

    check("sb_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/washer_phase_timer.md
# washer_phase_timer

Programmable phase-duration timer for the washing-machine controller. Sits directly beside the cycle FSM:
- consumes its `timer_enable`, `phase_sel` and latched mode;
- returns `timer_done` when the active phase (soak/wash/rinse/spin) has run its mode-dependent duration.

Counting is in prescaled "units", pauses while the lid is open, and reloads automatically on every phase change.

## Interface
- `TICK_DIV`, 1000 — clock cycles per time unit (≥2)
- `CNT_W`, 8 — width of unit counter / `remaining`
- `SOAK_T`, 6 — normal-mode soak duration, units
- `WASH_T`, 10 — normal-mode wash duration, units
- `RINSE_T`, 4 — normal-mode rinse duration, units
- `SPIN_T`, 5 — normal-mode spin duration, units

Ports:
- `clk` in 1 — single clock
- `rst_n` in 1 — asynchronous, active-low reset
- `timer_enable` in 1 — phase timing requested
- `phase_sel` in 2 — 00 soak, 01 wash, 10 rinse, 11 spin
- `mode` in 3 — latched {mode1,mode2,mode3}
- `pause` in 1 — lid open; freezes counting
- `timer_done` out 1 — phase duration elapsed (level)
- `running` out 1 — actively counting
- `remaining` out CNT_W — units left in current phase

## Operation
- States: IDLE, COUNT, DONE.
- Duration D = base(phase_sel) scaled by mode:
  - `mode[2]` (heavy): base<<1.
  - else `mode[1]` (normal): base.
  - else `mode[0]` (quick): base>>1.
  - 000: base.
- Width rules for D:
  - Computed in CNT_W+1 bits; saturates to 2^CNT_W−1.
  - A result of 0 is clamped to 1.
- Reload condition R = `timer_enable` && (!en_q || `phase_sel` != phase_q). `en_q` and `phase_q` are registered copies of the inputs, reset to 0/00.
- On R, in any state:
  - `remaining` ← D, prescaler ← 0, state ← COUNT.
  - `timer_done` ← 0.
  - `mode` is sampled only here; mode changes mid-phase are ignored.
- COUNT, `pause`=0:
  - Prescaler increments each cycle.
  - At TICK_DIV−1 it wraps to 0 and `remaining` decrements.
  - A decrement to 0 moves to DONE and sets `timer_done`=1.
- COUNT, `pause`=1: prescaler and `remaining` hold.
- DONE:
  - `timer_done` stays 1 and `remaining`=0 until R or `timer_enable`=0.
  - `pause` has no effect; done is held, so a lid-blocked FSM advances later.
- `timer_enable`=0, any state: next cycle → IDLE; `remaining`, prescaler, `timer_done` ← 0.
- Priority: `timer_enable`=0 > R > tick > hold.
- `running` = (state==COUNT) && !`pause`, combinational from the registered state.

## Timing
- Reset: state IDLE; `timer_done`=0, `running`=0, `remaining`=0, prescaler 0, `en_q`=0, `phase_q`=00.
- Reload latency: R sampled at edge E0 → `remaining`=D visible after E0.
- Done latency:
  - With no pause, `timer_done` rises after edge E0+D·TICK_DIV.
  - Each paused cycle adds exactly one cycle.
- `timer_done` is registered. The FSM samples it one edge later and changes `phase_sel`. R then fires at the following edge, so `timer_done` drops one cycle after the phase change.
- Phase change during COUNT (e.g. abnormal jump) reloads immediately; the old count is discarded.
- Enable drop and phase change in the same cycle → IDLE (no reload).
- Re-enable after cancel always reloads from full D.
- Reset mid-count: all outputs to reset values asynchronously; no `timer_done` pulse.

## Test plan
- Normal soak:
  - Stimulus: TICK_DIV=4, mode=010, enable↑ with phase 00.
  - Response: `remaining`=6 after load; decrements every 4 cycles; `timer_done`=1 exactly 24 cycles after load edge and held.
- Heavy wash and quick rinse:
  - Heavy wash (mode=100, phase 01) → D=20, done at 80 cycles.
  - Quick rinse (mode=001, phase 10) → D=2, done at 8 cycles.
- Pause:
  - Stimulus: normal soak, `pause`=1 for 10 cycles starting at cycle 5.
  - Response: `remaining` and prescaler frozen, `running`=0; done at cycle 34.
  - Additionally, pause asserted while in DONE keeps `timer_done`=1.
- Phase advance:
  - Stimulus: in DONE, `phase_sel` 00→01 with enable held.
  - Response: next edge `timer_done`=0, `remaining`=10, counting resumes.
- Cancel/reset:
  - Enable drop at `remaining`=3 → next cycle IDLE, `remaining`=0, `timer_done`=0; re-enable reloads full D.
  - `rst_n` low mid-count clears outputs immediately.
- Saturation:
  - Stimulus: WASH_T=200, CNT_W=8, heavy mode.
  - Response: D=255.
  - Also: SPIN_T=1 in quick mode → D clamped to 1, done after TICK_DIV cycles.
